// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the serial ALU: packet types, serializer FSM states,
// flag/error encodings and the CRC3 used by both the serializer and the checker.
package mtm_alu_pkg;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CTL  = 1'b1;

  localparam int FLAG_CARRY    = 3;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_ZERO     = 1;
  localparam int FLAG_NEGATIVE = 0;

  // err_flags carries each error bit twice: {DATA, CRC, OP, DATA, CRC, OP}
  localparam int ERR_DATA_HI = 5;
  localparam int ERR_CRC_HI  = 4;
  localparam int ERR_OP_HI   = 3;
  localparam int ERR_DATA_LO = 2;
  localparam int ERR_CRC_LO  = 1;
  localparam int ERR_OP_LO   = 0;

  localparam logic [7:0] CTL_ERR_DATA = 8'hC9;
  localparam logic [7:0] CTL_ERR_CRC  = 8'hA5;
  localparam logic [7:0] CTL_ERR_OP   = 8'h93;

  localparam logic [2:0] CRC3_POLY = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TYPE,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } state_t;

  typedef struct packed {
    logic [39:0] img;
    logic [4:0]  typ;
    logic        err;
  } frame_t;

  // MSB-first CRC over x^3+x+1 with zero init, i.e. msg*x^3 mod g
  function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1:0], 1'b0} ^ (fb ? CRC3_POLY : 3'b000);
    end
    return crc;
  endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// Result bus between the ALU core (master) and the output serializer (slave).
interface mtm_alu_serializer_if;
  logic        res_valid;
  logic [31:0] C;
  logic [3:0]  flags;
  logic        err;
  logic [5:0]  err_flags;
  logic        sout;
  logic        busy;
  logic        overrun;

  modport master (
    output res_valid, C, flags, err, err_flags,
    input  sout, busy, overrun
  );

  modport slave (
    input  res_valid, C, flags, err, err_flags,
    output sout, busy, overrun
  );
endinterface

// File: rtl/mtm_alu_crc3.sv
// Combinational 37-bit to 3-bit CRC wrapper around the package function.
module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic [36:0] msg,
  output logic [2:0]  crc
);

  assign crc = crc3_calc(msg);

endmodule

// File: rtl/mtm_alu_serializer.sv
// Output stage of the serial ALU: frames one result or error report into 11-bit
// packets on sout, with a single pending slot so a second strobe is not lost.
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int IDLE_GAP = 0
) (
  input logic                  clk,
  input logic                  rst_n,
  mtm_alu_serializer_if.slave  bus
);

  localparam logic [3:0] GAP_LAST = 4'(IDLE_GAP - 1);

  state_t      state;
  frame_t      pend;
  logic        pend_full;
  logic [39:0] sh_img;
  logic [4:0]  sh_type;
  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic [3:0]  gap_cnt;
  logic        sout_q;
  logic        busy_q;
  logic        overrun_q;

  logic [2:0]  crc3;
  frame_t      new_frame;
  frame_t      load_frame;
  logic        frame_end;
  logic        start_pend;
  logic        start_new;
  logic        to_pend;
  logic        drop;

  mtm_alu_crc3 u_crc3 (
    .msg ({bus.C, 1'b0, bus.flags}),
    .crc (crc3)
  );

  // Error frames put their single ctl byte at the top so it shifts out first
  always_comb begin
    new_frame = '0;
    if (bus.err) begin
      new_frame.img = {1'b1, bus.err_flags, ~(^bus.err_flags), 32'h0};
      new_frame.typ = {PKT_CTL, {4{PKT_DATA}}};
      new_frame.err = 1'b1;
    end else begin
      new_frame.img = {bus.C, 1'b0, bus.flags, crc3};
      new_frame.typ = {{4{PKT_DATA}}, PKT_CTL};
      new_frame.err = 1'b0;
    end
  end

  // Pending is freed in the frame-end cycle, so a strobe there can refill it
  always_comb begin
    if (IDLE_GAP == 0) begin
      frame_end = (state == ST_STOP) && (byte_cnt == 3'd4);
    end else begin
      frame_end = (state == ST_GAP) && (gap_cnt == GAP_LAST);
    end
    start_pend = pend_full && ((state == ST_IDLE) || frame_end);
    start_new  = bus.res_valid && (state == ST_IDLE) && !pend_full;
    to_pend    = bus.res_valid && !start_new && (!pend_full || start_pend);
    drop       = bus.res_valid && !start_new && !to_pend;
    load_frame = start_pend ? pend : new_frame;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pend      <= '0;
      pend_full <= 1'b0;
      sh_img    <= '0;
      sh_type   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      busy_q    <= (state != ST_IDLE) || pend_full;
      overrun_q <= overrun_q || drop;

      if (to_pend) begin
        pend      <= new_frame;
        pend_full <= 1'b1;
      end else if (start_pend) begin
        pend_full <= 1'b0;
      end

      case (state)
        ST_IDLE: sout_q <= 1'b1;
        ST_START: begin
          sout_q <= 1'b0;
          state  <= ST_TYPE;
        end
        ST_TYPE: begin
          sout_q  <= sh_type[4];
          bit_cnt <= 3'd7;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          sout_q <= sh_img[39];
          sh_img <= {sh_img[38:0], 1'b0};
          if (bit_cnt == 3'd0) begin
            state <= ST_STOP;
          end else begin
            bit_cnt <= bit_cnt - 3'd1;
          end
        end
        ST_STOP: begin
          sout_q  <= 1'b1;
          sh_type <= {sh_type[3:0], 1'b0};
          if (byte_cnt != 3'd4) begin
            byte_cnt <= byte_cnt + 3'd1;
            state    <= ST_START;
          end else if (IDLE_GAP != 0) begin
            state <= ST_GAP;
          end else begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
          end
        end
        ST_GAP: begin
          sout_q <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            gap_cnt  <= '0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A new frame start overrides whatever the case above chose
      if (start_pend || start_new) begin
        sh_img   <= load_frame.img;
        sh_type  <= load_frame.typ;
        byte_cnt <= load_frame.err ? 3'd4 : 3'd0;
        bit_cnt  <= '0;
        gap_cnt  <= '0;
        state    <= ST_START;
      end
    end
  end

  assign bus.sout    = sout_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Directed bench for mtm_alu_serializer: a reference packet decoder on sout pops
// expected {type, byte} entries from a scoreboard filled when each strobe is driven.
module tb_mtm_alu_serializer;
  import mtm_alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [8:0] sb[$];
  logic [9:0] dec_pkt;
  logic       dec_abort;

  mtm_alu_serializer_if bus ();

  mtm_alu_serializer #(.IDLE_GAP(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    waitCycles(2);
    while (bus.busy !== 1'b0 && k < limit) begin
      waitCycles(1);
      k++;
    end
    checkOutput("idle_timeout", 32'(k < limit), 32'd1);
  endtask

  // Strobe sampled at the posedge following the drive; returns #1 after it
  task automatic applyStimulus(input logic [31:0] c, input logic [3:0] fl,
                               input logic e, input logic [5:0] ef);
    @(negedge clk);
    bus.res_valid = 1'b1;
    bus.C         = c;
    bus.flags     = fl;
    bus.err       = e;
    bus.err_flags = ef;
    @(posedge clk);
    #1;
    bus.res_valid = 1'b0;
  endtask

  // Reference CRC by polynomial long division of {C,0,flags}*x^3 by 4'b1011
  task automatic expectResult(input logic [31:0] c, input logic [3:0] fl);
    logic [39:0] r;
    r = {c, 1'b0, fl, 3'b000};
    for (int i = 39; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    for (int k = 3; k >= 0; k--) sb.push_back({PKT_DATA, c[8*k +: 8]});
    sb.push_back({PKT_CTL, 1'b0, fl, r[2:0]});
  endtask

  task automatic expectCtl(input logic [7:0] b);
    sb.push_back({PKT_CTL, b});
  endtask

  function automatic logic [7:0] errCtl(input logic [5:0] ef);
    return {1'b1, ef, 1'((1 + $countones(ef)) % 2)};
  endfunction

  always begin : ref_decoder
    @(negedge clk);
    if (rst_n === 1'b1 && bus.sout === 1'b0) begin
      dec_abort = 1'b0;
      for (int i = 9; i >= 0; i--) begin
        @(negedge clk);
        if (rst_n !== 1'b1) dec_abort = 1'b1;
        dec_pkt[i] = bus.sout;
      end
      if (!dec_abort) begin
        checkOutput("stop_bit", {31'd0, dec_pkt[0]}, 32'd1);
        n_assert++;
        assert (sb.size() != 0) else begin
          n_fail++;
          $error("[TB] FAIL unexpected_pkt observed=%0h expected=none", dec_pkt[9:1]);
        end
        if (sb.size() != 0) checkOutput("pkt", {23'd0, dec_pkt[9:1]}, {23'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    bus.res_valid = 1'b0;
    bus.C         = '0;
    bus.flags     = '0;
    bus.err       = 1'b0;
    bus.err_flags = '0;
    waitCycles(3);
    checkOutput("rst_sout", {31'd0, bus.sout}, 32'd1);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] result frame C=0 flags=0010");
    expectResult(32'h0, 4'b0010);
    applyStimulus(32'h0, 4'b0010, 1'b0, 6'b0);
    checkOutput("t1_pre_start", {31'd0, bus.sout}, 32'd1);
    waitCycles(1);
    checkOutput("t1_start", {31'd0, bus.sout}, 32'd0);
    checkOutput("t1_busy", {31'd0, bus.busy}, 32'd1);
    waitCycles(54);
    checkOutput("t1_last_stop", {31'd0, bus.sout}, 32'd1);
    checkOutput("t1_busy55", {31'd0, bus.busy}, 32'd1);
    waitCycles(1);
    checkOutput("t1_busy56", {31'd0, bus.busy}, 32'd0);

    $display("[TB] error frames");
    expectCtl(CTL_ERR_DATA);
    applyStimulus(32'hFFFF_FFFF, 4'hF, 1'b1, 6'b100100);
    waitCycles(1);
    checkOutput("t2_start", {31'd0, bus.sout}, 32'd0);
    waitCycles(10);
    checkOutput("t2_stop", {31'd0, bus.sout}, 32'd1);
    checkOutput("t2_busy11", {31'd0, bus.busy}, 32'd1);
    waitCycles(1);
    checkOutput("t2_busy12", {31'd0, bus.busy}, 32'd0);
    expectCtl(CTL_ERR_CRC);
    applyStimulus(32'h0, 4'h0, 1'b1, 6'b010010);
    waitIdle(20);
    expectCtl(CTL_ERR_OP);
    applyStimulus(32'h1234_5678, 4'h5, 1'b1, 6'b001001);
    waitIdle(20);

    $display("[TB] back-to-back via pending");
    expectResult(32'hDEAD_BEEF, 4'b1001);
    applyStimulus(32'hDEAD_BEEF, 4'b1001, 1'b0, 6'b0);
    repeat (4) @(posedge clk);
    expectCtl(errCtl(6'b001001));
    applyStimulus(32'h0, 4'h0, 1'b1, 6'b001001);
    waitCycles(50);
    checkOutput("t4_stop1", {31'd0, bus.sout}, 32'd1);
    waitCycles(1);
    checkOutput("t4_start2", {31'd0, bus.sout}, 32'd0);
    checkOutput("t4_busy", {31'd0, bus.busy}, 32'd1);
    waitIdle(30);
    checkOutput("t4_overrun", {31'd0, bus.overrun}, 32'd0);

    $display("[TB] overrun");
    expectResult(32'h1234_5678, 4'b0100);
    applyStimulus(32'h1234_5678, 4'b0100, 1'b0, 6'b0);
    @(posedge clk);
    expectResult(32'h8000_0001, 4'b1010);
    applyStimulus(32'h8000_0001, 4'b1010, 1'b0, 6'b0);
    @(posedge clk);
    applyStimulus(32'hCAFE_F00D, 4'b1111, 1'b0, 6'b0);
    checkOutput("t5_overrun", {31'd0, bus.overrun}, 32'd1);
    checkOutput("t5_busy", {31'd0, bus.busy}, 32'd1);
    waitIdle(200);
    checkOutput("t5_overrun_sticky", {31'd0, bus.overrun}, 32'd1);

    $display("[TB] reset mid-frame");
    expectResult(32'hA5A5_0F0F, 4'b0001);
    applyStimulus(32'hA5A5_0F0F, 4'b0001, 1'b0, 6'b0);
    waitCycles(19);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("t6_sout", {31'd0, bus.sout}, 32'd1);
    checkOutput("t6_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("t6_overrun", {31'd0, bus.overrun}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    expectResult(32'h7FFF_FFFF, 4'b1100);
    applyStimulus(32'h7FFF_FFFF, 4'b1100, 1'b0, 6'b0);
    waitCycles(1);
    checkOutput("t6_start", {31'd0, bus.sout}, 32'd0);
    waitIdle(80);

    waitCycles(3);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
